// File: rtl/multicycle_controller.sv
// Control FSM for the multi-cycle RV32I datapath. Sequences fetch/decode/execute for
// lw, sw, R-type, I-type ALU, beq and jal, and drives datapath enables, mux selects and
// the 4-bit ALU operation code. Moore-style except pc_write in BEQ, which follows zero.
module multicycle_controller #(
   parameter bit ILLEGAL_TRAP = 1'b1  // 1: illegal instr locks in ERROR; 0: skipped as NOP
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
   output logic       pc_write,
   output logic       adr_src,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_write,
   output logic [1:0] result_src,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] imm_src,
   output logic [3:0] alu_control,
   output logic       instr_done,
   output logic       illegal,
   output logic [3:0] state_dbg
);

   typedef enum logic [3:0] {
      StFetch    = 4'd0,
      StDecode   = 4'd1,
      StMemAdr   = 4'd2,
      StMemRead  = 4'd3,
      StMemWb    = 4'd4,
      StMemWrite = 4'd5,
      StExecR    = 4'd6,
      StExecI    = 4'd7,
      StAluWb    = 4'd8,
      StBeq      = 4'd9,
      StJal      = 4'd10,
      StError    = 4'd11
   } state_e;

   localparam logic [6:0] OpLoad  = 7'b0000011;
   localparam logic [6:0] OpStore = 7'b0100011;
   localparam logic [6:0] OpRType = 7'b0110011;
   localparam logic [6:0] OpIType = 7'b0010011;
   localparam logic [6:0] OpBeq   = 7'b1100011;
   localparam logic [6:0] OpJal   = 7'b1101111;

   localparam logic [3:0] AluAnd = 4'b0000;
   localparam logic [3:0] AluOr  = 4'b0001;
   localparam logic [3:0] AluAdd = 4'b0010;
   localparam logic [3:0] AluSub = 4'b0110;
   localparam logic [3:0] AluSlt = 4'b0111;
   localparam logic [3:0] AluXor = 4'b1100;

   localparam state_e IllegalNext = ILLEGAL_TRAP ? StError : StFetch;

   state_e     state_q, state_d;
   logic [3:0] alu_dec;
   logic       funct3_ok;

   // State register; reset forces FETCH immediately, abandoning any instruction.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StFetch;
      end else begin
         state_q <= state_d;
      end
   end

   // funct3 -> ALU op for the execute states; unsupported encodings flag illegal.
   always_comb begin
      alu_dec   = AluAdd;
      funct3_ok = 1'b1;
      unique case (funct3)
         3'b000:  alu_dec = AluAdd;
         3'b010:  alu_dec = AluSlt;
         3'b100:  alu_dec = AluXor;
         3'b110:  alu_dec = AluOr;
         3'b111:  alu_dec = AluAnd;
         default: funct3_ok = 1'b0;
      endcase
   end

   // Immediate format follows the opcode alone, independent of state.
   always_comb begin
      imm_src = 2'b00;
      unique case (op)
         OpStore: imm_src = 2'b01;
         OpBeq:   imm_src = 2'b10;
         OpJal:   imm_src = 2'b11;
         default: imm_src = 2'b00;
      endcase
   end

   // Next-state and per-state outputs; enables are masked while reset is held.
   always_comb begin
      state_d     = state_q;
      pc_write    = 1'b0;
      adr_src     = 1'b0;
      mem_write   = 1'b0;
      ir_write    = 1'b0;
      reg_write   = 1'b0;
      result_src  = 2'b00;
      alu_src_a   = 2'b00;
      alu_src_b   = 2'b00;
      alu_control = AluAnd;
      instr_done  = 1'b0;
      illegal     = 1'b0;

      unique case (state_q)
         StFetch: begin
            ir_write    = 1'b1;
            alu_src_b   = 2'b10;
            alu_control = AluAdd;
            result_src  = 2'b10;
            pc_write    = 1'b1;
            state_d     = StDecode;
         end
         StDecode: begin
            // Precompute PC-relative target into ALUOut for beq/jal.
            alu_src_a   = 2'b01;
            alu_src_b   = 2'b01;
            alu_control = AluAdd;
            unique case (op)
               OpLoad, OpStore: state_d = StMemAdr;
               OpRType:         state_d = StExecR;
               OpIType:         state_d = StExecI;
               OpBeq:           state_d = StBeq;
               OpJal:           state_d = StJal;
               default:         state_d = IllegalNext;
            endcase
         end
         StMemAdr: begin
            alu_src_a   = 2'b10;
            alu_src_b   = 2'b01;
            alu_control = AluAdd;
            state_d     = (op == OpStore) ? StMemWrite : StMemRead;
         end
         StMemRead: begin
            adr_src = 1'b1;
            state_d = StMemWb;
         end
         StMemWb: begin
            result_src = 2'b01;
            reg_write  = 1'b1;
            instr_done = 1'b1;
            state_d    = StFetch;
         end
         StMemWrite: begin
            adr_src    = 1'b1;
            mem_write  = 1'b1;
            instr_done = 1'b1;
            state_d    = StFetch;
         end
         StExecR: begin
            alu_src_a   = 2'b10;
            alu_src_b   = 2'b00;
            alu_control = (funct3 == 3'b000 && funct7b5) ? AluSub : alu_dec;
            state_d     = funct3_ok ? StAluWb : IllegalNext;
         end
         StExecI: begin
            // funct7b5 ignored: there is no SUBI.
            alu_src_a   = 2'b10;
            alu_src_b   = 2'b01;
            alu_control = alu_dec;
            state_d     = funct3_ok ? StAluWb : IllegalNext;
         end
         StAluWb: begin
            result_src = 2'b00;
            reg_write  = 1'b1;
            instr_done = 1'b1;
            state_d    = StFetch;
         end
         StBeq: begin
            alu_src_a   = 2'b10;
            alu_src_b   = 2'b00;
            alu_control = AluSub;
            result_src  = 2'b00;
            pc_write    = zero;
            instr_done  = 1'b1;
            state_d     = StFetch;
         end
         StJal: begin
            // PC <- ALUOut (target from DECODE) while ALU forms OldPC+4 for rd.
            alu_src_a   = 2'b01;
            alu_src_b   = 2'b10;
            alu_control = AluAdd;
            result_src  = 2'b00;
            pc_write    = 1'b1;
            state_d     = StAluWb;
         end
         StError: begin
            illegal = 1'b1;
            state_d = StError;
         end
         default: begin
            state_d = StFetch;
         end
      endcase

      if (reset) begin
         pc_write   = 1'b0;
         mem_write  = 1'b0;
         ir_write   = 1'b0;
         reg_write  = 1'b0;
         instr_done = 1'b0;
         illegal    = 1'b0;
      end
   end

   assign state_dbg = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller. Two instances share stimulus: one traps
// illegal instructions (ILLEGAL_TRAP=1), the other skips them (ILLEGAL_TRAP=0).
module tb_multicycle_controller;

   typedef struct packed {
      logic [3:0] st;
      logic       pcw;
      logic       adr;
      logic       mw;
      logic       irw;
      logic       rw;
      logic [1:0] res;
      logic [1:0] sa;
      logic [1:0] sb;
      logic [1:0] imm;
      logic [3:0] alu;
      logic       done;
      logic       ill;
      logic [3:0] stb;
   } exp_t;

   localparam logic [6:0] LW  = 7'b0000011;
   localparam logic [6:0] SW  = 7'b0100011;
   localparam logic [6:0] RT  = 7'b0110011;
   localparam logic [6:0] IT  = 7'b0010011;
   localparam logic [6:0] BQ  = 7'b1100011;
   localparam logic [6:0] JL  = 7'b1101111;
   localparam logic [6:0] BAD = 7'b1111111;

   logic       clk;
   logic       reset;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       zero;

   logic       pc_write, adr_src, mem_write, ir_write, reg_write, instr_done, illegal;
   logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
   logic [3:0] alu_control, state_dbg;

   logic       b_pc_write, b_adr_src, b_mem_write, b_ir_write, b_reg_write;
   logic       b_instr_done, b_illegal;
   logic [1:0] b_result_src, b_alu_src_a, b_alu_src_b, b_imm_src;
   logic [3:0] b_alu_control, b_state_dbg;

   exp_t  exp_q[$];
   string name_q[$];
   int    n_checks = 0;
   int    n_pass   = 0;

   multicycle_controller #(.ILLEGAL_TRAP(1'b1)) u_dut_trap (
      .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
      .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
      .reg_write(reg_write), .result_src(result_src), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .imm_src(imm_src), .alu_control(alu_control),
      .instr_done(instr_done), .illegal(illegal), .state_dbg(state_dbg)
   );

   multicycle_controller #(.ILLEGAL_TRAP(1'b0)) u_dut_skip (
      .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
      .pc_write(b_pc_write), .adr_src(b_adr_src), .mem_write(b_mem_write),
      .ir_write(b_ir_write), .reg_write(b_reg_write), .result_src(b_result_src),
      .alu_src_a(b_alu_src_a), .alu_src_b(b_alu_src_b), .imm_src(b_imm_src),
      .alu_control(b_alu_control), .instr_done(b_instr_done), .illegal(b_illegal),
      .state_dbg(b_state_dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Build an expected vector from hand-computed field values.
   function automatic exp_t e(input int st, input int pcw, input int adr, input int mw,
                              input int irw, input int rw, input int res, input int sa,
                              input int sb, input int imm, input int alu, input int done,
                              input int ill, input int stb);
      exp_t x;
      x.st   = 4'(st);
      x.pcw  = 1'(pcw);
      x.adr  = 1'(adr);
      x.mw   = 1'(mw);
      x.irw  = 1'(irw);
      x.rw   = 1'(rw);
      x.res  = 2'(res);
      x.sa   = 2'(sa);
      x.sb   = 2'(sb);
      x.imm  = 2'(imm);
      x.alu  = 4'(alu);
      x.done = 1'(done);
      x.ill  = 1'(ill);
      x.stb  = 4'(stb);
      return x;
   endfunction

   // Drive one cycle of inputs just after the edge and queue what should be seen.
   task automatic step(input string nm, input logic r, input logic [6:0] o,
                       input logic [2:0] f3, input logic f7, input logic z, input exp_t ex);
      @(posedge clk);
      #1;
      reset    = r;
      op       = o;
      funct3   = f3;
      funct7b5 = f7;
      zero     = z;
      exp_q.push_back(ex);
      name_q.push_back(nm);
   endtask

   // Monitor: compare outputs mid-cycle against the next queued expectation.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t  ex;
         exp_t  act;
         string nm;
         ex  = exp_q.pop_front();
         nm  = name_q.pop_front();
         act.st   = state_dbg;
         act.pcw  = pc_write;
         act.adr  = adr_src;
         act.mw   = mem_write;
         act.irw  = ir_write;
         act.rw   = reg_write;
         act.res  = result_src;
         act.sa   = alu_src_a;
         act.sb   = alu_src_b;
         act.imm  = imm_src;
         act.alu  = alu_control;
         act.done = instr_done;
         act.ill  = illegal;
         act.stb  = b_state_dbg;
         n_checks++;
         if (act === ex) begin
            n_pass++;
         end else begin
            $display("FAIL %s: got st=%0d pcw=%b adr=%b mw=%b irw=%b rw=%b res=%b sa=%b sb=%b imm=%b alu=%b done=%b ill=%b stb=%0d ; want st=%0d pcw=%b adr=%b mw=%b irw=%b rw=%b res=%b sa=%b sb=%b imm=%b alu=%b done=%b ill=%b stb=%0d",
                     nm, act.st, act.pcw, act.adr, act.mw, act.irw, act.rw, act.res, act.sa,
                     act.sb, act.imm, act.alu, act.done, act.ill, act.stb,
                     ex.st, ex.pcw, ex.adr, ex.mw, ex.irw, ex.rw, ex.res, ex.sa, ex.sb,
                     ex.imm, ex.alu, ex.done, ex.ill, ex.stb);
         end
      end
   end

   initial begin
      reset    = 1'b1;
      op       = LW;
      funct3   = 3'b000;
      funct7b5 = 1'b0;
      zero     = 1'b0;

      //   name            rst op   f3     f7 z   st pcw adr mw irw rw res sa sb imm alu done ill stb
      // lw: 0,1,2,3,4 then back to FETCH
      step("rst_hold",     1, LW,  3'd0, 0, 0, e(0, 0, 0, 0, 0, 0, 2, 0, 2, 0,  2, 0, 0, 0));
      step("lw_fetch",     0, LW,  3'd0, 0, 0, e(0, 1, 0, 0, 1, 0, 2, 0, 2, 0,  2, 0, 0, 0));
      step("lw_decode",    0, LW,  3'd0, 0, 0, e(1, 0, 0, 0, 0, 0, 0, 1, 1, 0,  2, 0, 0, 1));
      step("lw_memadr",    0, LW,  3'd0, 0, 0, e(2, 0, 0, 0, 0, 0, 0, 2, 1, 0,  2, 0, 0, 2));
      step("lw_memread",   0, LW,  3'd0, 0, 0, e(3, 0, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 3));
      step("lw_memwb",     0, LW,  3'd0, 0, 0, e(4, 0, 0, 0, 0, 1, 1, 0, 0, 0,  0, 1, 0, 4));
      // R-type sub
      step("sub_fetch",    0, RT,  3'd0, 1, 0, e(0, 1, 0, 0, 1, 0, 2, 0, 2, 0,  2, 0, 0, 0));
      step("sub_decode",   0, RT,  3'd0, 1, 0, e(1, 0, 0, 0, 0, 0, 0, 1, 1, 0,  2, 0, 0, 1));
      step("sub_execr",    0, RT,  3'd0, 1, 0, e(6, 0, 0, 0, 0, 0, 0, 2, 0, 0,  6, 0, 0, 6));
      step("sub_aluwb",    0, RT,  3'd0, 1, 0, e(8, 0, 0, 0, 0, 1, 0, 0, 0, 0,  0, 1, 0, 8));
      // addi with funct7b5 set must stay ADD
      step("addi_fetch",   0, IT,  3'd0, 1, 0, e(0, 1, 0, 0, 1, 0, 2, 0, 2, 0,  2, 0, 0, 0));
      step("addi_decode",  0, IT,  3'd0, 1, 0, e(1, 0, 0, 0, 0, 0, 0, 1, 1, 0,  2, 0, 0, 1));
      step("addi_execi",   0, IT,  3'd0, 1, 0, e(7, 0, 0, 0, 0, 0, 0, 2, 1, 0,  2, 0, 0, 7));
      step("addi_aluwb",   0, IT,  3'd0, 1, 0, e(8, 0, 0, 0, 0, 1, 0, 0, 0, 0,  0, 1, 0, 8));
      // xori
      step("xori_fetch",   0, IT,  3'd4, 0, 0, e(0, 1, 0, 0, 1, 0, 2, 0, 2, 0,  2, 0, 0, 0));
      step("xori_decode",  0, IT,  3'd4, 0, 0, e(1, 0, 0, 0, 0, 0, 0, 1, 1, 0,  2, 0, 0, 1));
      step("xori_execi",   0, IT,  3'd4, 0, 0, e(7, 0, 0, 0, 0, 0, 0, 2, 1, 0, 12, 0, 0, 7));
      step("xori_aluwb",   0, IT,  3'd4, 0, 0, e(8, 0, 0, 0, 0, 1, 0, 0, 0, 0,  0, 1, 0, 8));
      // slt
      step("slt_fetch",    0, RT,  3'd2, 0, 0, e(0, 1, 0, 0, 1, 0, 2, 0, 2, 0,  2, 0, 0, 0));
      step("slt_decode",   0, RT,  3'd2, 0, 0, e(1, 0, 0, 0, 0, 0, 0, 1, 1, 0,  2, 0, 0, 1));
      step("slt_execr",    0, RT,  3'd2, 0, 0, e(6, 0, 0, 0, 0, 0, 0, 2, 0, 0,  7, 0, 0, 6));
      step("slt_aluwb",    0, RT,  3'd2, 0, 0, e(8, 0, 0, 0, 0, 1, 0, 0, 0, 0,  0, 1, 0, 8));
      // beq taken / not taken
      step("beqt_fetch",   0, BQ,  3'd0, 0, 1, e(0, 1, 0, 0, 1, 0, 2, 0, 2, 2,  2, 0, 0, 0));
      step("beqt_decode",  0, BQ,  3'd0, 0, 1, e(1, 0, 0, 0, 0, 0, 0, 1, 1, 2,  2, 0, 0, 1));
      step("beq_taken",    0, BQ,  3'd0, 0, 1, e(9, 1, 0, 0, 0, 0, 0, 2, 0, 2,  6, 1, 0, 9));
      step("beqn_fetch",   0, BQ,  3'd0, 0, 0, e(0, 1, 0, 0, 1, 0, 2, 0, 2, 2,  2, 0, 0, 0));
      step("beqn_decode",  0, BQ,  3'd0, 0, 0, e(1, 0, 0, 0, 0, 0, 0, 1, 1, 2,  2, 0, 0, 1));
      step("beq_nottaken", 0, BQ,  3'd0, 0, 0, e(9, 0, 0, 0, 0, 0, 0, 2, 0, 2,  6, 1, 0, 9));
      // sw
      step("sw_fetch",     0, SW,  3'd2, 0, 0, e(0, 1, 0, 0, 1, 0, 2, 0, 2, 1,  2, 0, 0, 0));
      step("sw_decode",    0, SW,  3'd2, 0, 0, e(1, 0, 0, 0, 0, 0, 0, 1, 1, 1,  2, 0, 0, 1));
      step("sw_memadr",    0, SW,  3'd2, 0, 0, e(2, 0, 0, 0, 0, 0, 0, 2, 1, 1,  2, 0, 0, 2));
      step("sw_memwrite",  0, SW,  3'd2, 0, 0, e(5, 0, 1, 1, 0, 0, 0, 0, 0, 1,  0, 1, 0, 5));
      // jal
      step("jal_fetch",    0, JL,  3'd0, 0, 0, e(0, 1, 0, 0, 1, 0, 2, 0, 2, 3,  2, 0, 0, 0));
      step("jal_decode",   0, JL,  3'd0, 0, 0, e(1, 0, 0, 0, 0, 0, 0, 1, 1, 3,  2, 0, 0, 1));
      step("jal_exec",     0, JL,  3'd0, 0, 0, e(10, 1, 0, 0, 0, 0, 0, 1, 2, 3, 2, 0, 0, 10));
      step("jal_aluwb",    0, JL,  3'd0, 0, 0, e(8, 0, 0, 0, 0, 1, 0, 0, 0, 3,  0, 1, 0, 8));
      // illegal R-type funct3 001: trap instance locks, skip instance refetches
      step("badf3_fetch",  0, RT,  3'd1, 0, 0, e(0, 1, 0, 0, 1, 0, 2, 0, 2, 0,  2, 0, 0, 0));
      step("badf3_decode", 0, RT,  3'd1, 0, 0, e(1, 0, 0, 0, 0, 0, 0, 1, 1, 0,  2, 0, 0, 1));
      step("badf3_execr",  0, RT,  3'd1, 0, 0, e(6, 0, 0, 0, 0, 0, 0, 2, 0, 0,  2, 0, 0, 6));
      step("badf3_trap",   0, RT,  3'd1, 0, 0, e(11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
      step("error_hold",   0, RT,  3'd1, 0, 0, e(11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
      // only reset leaves ERROR; then an unknown opcode
      step("rst_clear",    1, LW,  3'd0, 0, 0, e(0, 0, 0, 0, 0, 0, 2, 0, 2, 0,  2, 0, 0, 0));
      step("badop_fetch",  0, BAD, 3'd0, 0, 0, e(0, 1, 0, 0, 1, 0, 2, 0, 2, 0,  2, 0, 0, 0));
      step("badop_decode", 0, BAD, 3'd0, 0, 0, e(1, 0, 0, 0, 0, 0, 0, 1, 1, 0,  2, 0, 0, 1));
      step("badop_trap",   0, BAD, 3'd0, 0, 0, e(11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
      step("badop_hold1",  0, BAD, 3'd0, 0, 0, e(11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
      step("badop_hold2",  0, BAD, 3'd0, 0, 0, e(11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
      // reset asserted while in MEMREAD of a lw
      step("rst_again",    1, LW,  3'd0, 0, 0, e(0, 0, 0, 0, 0, 0, 2, 0, 2, 0,  2, 0, 0, 0));
      step("lw2_fetch",    0, LW,  3'd0, 0, 0, e(0, 1, 0, 0, 1, 0, 2, 0, 2, 0,  2, 0, 0, 0));
      step("lw2_decode",   0, LW,  3'd0, 0, 0, e(1, 0, 0, 0, 0, 0, 0, 1, 1, 0,  2, 0, 0, 1));
      step("lw2_memadr",   0, LW,  3'd0, 0, 0, e(2, 0, 0, 0, 0, 0, 0, 2, 1, 0,  2, 0, 0, 2));
      step("rst_memread",  1, LW,  3'd0, 0, 0, e(0, 0, 0, 0, 0, 0, 2, 0, 2, 0,  2, 0, 0, 0));
      step("resume_fetch", 0, LW,  3'd0, 0, 0, e(0, 1, 0, 0, 1, 0, 2, 0, 2, 0,  2, 0, 0, 0));
      step("resume_decode",0, LW,  3'd0, 0, 0, e(1, 0, 0, 0, 0, 0, 0, 1, 1, 0,  2, 0, 0, 1));

      repeat (3) @(posedge clk);
      n_checks++;
      if (exp_q.size() == 0) begin
         n_pass++;
      end else begin
         $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
